x_rams32_delay_ctrl: RTL and testbench

Programmable-length delay line controller driving a bank of WIDTH single-port 32x1 distributed RAM slices (address, write-enable and data shared across slices). It sits directly upstream of the RAM slices: it generates the ADR0..ADR4, WE and I inputs and consumes each slice's asynchronous O output. Output data is the input stream delayed by DLY+1 clock-enabled cycles. An optional power-up sweep clears the RAM contents.

---
 rtl/x_rams32_delay_ctrl.sv | 118 +++++++++++
 tb/tb_x_rams32_delay_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/x_rams32_delay_ctrl.sv
// Delay-line controller for a bank of WIDTH 32x1 distributed RAM slices; delay is DLY+1 CE-cycles.
// Define X_RAMS32_DLY_CLEAR_EN to add the zeroing sweep after reset and after every DLY change.
module x_rams32_delay_ctrl #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIN,
    input  logic [4:0]       DLY,
    output logic             ADR0,
    output logic             ADR1,
    output logic             ADR2,
    output logic             ADR3,
    output logic             ADR4,
    output logic             WE,
    output logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] O_RAM,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic             BUSY
);

`ifdef X_RAMS32_DLY_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    state_t state_reg, state_next;
`endif

    logic [4:0]       ptr_reg, ptr_next;
    logic [4:0]       dly_q_reg;
    logic [5:0]       fill_reg, fill_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             dvalid_reg, dvalid_next;
    logic             clearing;
    logic             dly_change;
    logic             we_int;
    logic [5:0]       len;

`ifdef X_RAMS32_DLY_CLEAR_EN
    assign clearing = (state_reg == ST_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    assign dly_change = (DLY != dly_q_reg);
    assign len        = {1'b0, dly_q_reg} + 6'd1;

    always_comb begin
        ptr_next    = ptr_reg;
        fill_next   = fill_reg;
        dout_next   = dout_reg;
        dvalid_next = dvalid_reg;
        we_int      = 1'b0;
`ifdef X_RAMS32_DLY_CLEAR_EN
        state_next  = state_reg;
`endif
        if (clearing) begin
            we_int   = 1'b1;
            ptr_next = ptr_reg + 5'd1;
            if (ptr_reg == 5'd31) begin
                fill_next = 6'd0;
`ifdef X_RAMS32_DLY_CLEAR_EN
                state_next = ST_RUN;
`endif
            end
        end else if (dly_change) begin
            // Restart the ring; any CE on this edge is dropped so nothing lands at a stale address.
            dvalid_next = 1'b0;
            fill_next   = 6'd0;
            ptr_next    = 5'd0;
`ifdef X_RAMS32_DLY_CLEAR_EN
            state_next  = ST_CLEAR;
`endif
        end else if (CE) begin
            we_int      = 1'b1;
            dout_next   = O_RAM;
            ptr_next    = (ptr_reg == dly_q_reg) ? 5'd0 : ptr_reg + 5'd1;
            fill_next   = (fill_reg >= len) ? len : fill_reg + 6'd1;
            dvalid_next = (fill_reg == len);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_reg    <= 5'd0;
            fill_reg   <= 6'd0;
            dly_q_reg  <= DLY;
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
`ifdef X_RAMS32_DLY_CLEAR_EN
            state_reg  <= ST_CLEAR;
`endif
        end else begin
            ptr_reg    <= ptr_next;
            fill_reg   <= fill_next;
            dly_q_reg  <= DLY;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
`ifdef X_RAMS32_DLY_CLEAR_EN
            state_reg  <= state_next;
`endif
        end
    end

    // Each slice gets zeros during the sweep, otherwise its own DIN bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            assign I[gi] = clearing ? 1'b0 : DIN[gi];
        end
    endgenerate

    assign {ADR4, ADR3, ADR2, ADR1, ADR0} = ptr_reg;
    assign WE     = we_int & ~RST;
    assign DOUT   = dout_reg;
    assign DVALID = dvalid_reg;
    assign BUSY   = clearing;

endmodule

// File: tb/tb_x_rams32_delay_ctrl.sv
// Bench for x_rams32_delay_ctrl: behavioural 32xWIDTH RAM bank plus a delayed-sample scoreboard.
module tb_x_rams32_delay_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic [WIDTH-1:0] din;
    logic [4:0]       dly;
    logic             adr0, adr1, adr2, adr3, adr4;
    logic             we;
    logic [WIDTH-1:0] i_w;
    logic [WIDTH-1:0] o_ram;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             busy;
    logic [4:0]       adr;

    logic [WIDTH-1:0] mem [32] = '{default: 8'hA5};

    int               tests_run = 0;
    int               tests_failed = 0;
    logic [WIDTH-1:0] sb [$];
    int               cur_len;
    logic [4:0]       exp_ptr;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_dvalid;
    logic             exp_dout_known;
    logic             exp_busy_clear;

    always #5 clk = ~clk;

    x_rams32_delay_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .DIN(din), .DLY(dly),
        .ADR0(adr0), .ADR1(adr1), .ADR2(adr2), .ADR3(adr3), .ADR4(adr4),
        .WE(we), .I(i_w), .O_RAM(o_ram), .DOUT(dout), .DVALID(dvalid), .BUSY(busy)
    );

    assign adr   = {adr4, adr3, adr2, adr1, adr0};
    assign o_ram = mem[adr];

    always @(posedge clk) begin
        if (we) mem[adr] <= i_w;
    end

`ifdef X_RAMS32_DLY_CLEAR_EN
    initial exp_busy_clear = 1'b1;
`else
    initial exp_busy_clear = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int new_len);
        sb.delete();
        cur_len    = new_len;
        exp_ptr    = 5'd0;
        exp_dvalid = 1'b0;
    endtask

    // Sweep check: called 1 time unit after the edge that left the block in CLEAR at ptr 0.
    task automatic sweep();
`ifdef X_RAMS32_DLY_CLEAR_EN
        for (int k = 0; k < 32; k++) begin
            check("sweep_busy", busy, 1);
            check("sweep_we", we, 1);
            check("sweep_adr", adr, k);
            check("sweep_i", i_w, 0);
            @(posedge clk);
            #1;
        end
        check("sweep_end_busy", busy, 0);
        check("sweep_end_adr", adr, 0);
        check("sweep_end_dvalid", dvalid, 0);
        $display("[TB] clear sweep of 32 locations checked");
`endif
    endtask

    task automatic step(input logic c, input logic [WIDTH-1:0] d);
        @(negedge clk);
        ce  = c;
        din = d;
        #1;
        check("we_comb", we, c);
        check("i_data", i_w, d);
        @(posedge clk);
        #1;
        if (c) begin
            sb.push_back(d);
            exp_ptr = (int'(exp_ptr) == cur_len - 1) ? 5'd0 : exp_ptr + 5'd1;
            if (sb.size() > cur_len) begin
                exp_dout       = sb.pop_front();
                exp_dvalid     = 1'b1;
                exp_dout_known = 1'b1;
            end else begin
                exp_dvalid = 1'b0;
`ifdef X_RAMS32_DLY_CLEAR_EN
                exp_dout       = '0;
                exp_dout_known = 1'b1;
`else
                exp_dout_known = 1'b0;
`endif
            end
        end
        check("adr", adr, exp_ptr);
        check("dvalid", dvalid, exp_dvalid);
        if (exp_dout_known) check("dout", dout, exp_dout);
        $display("[TB] ce=%0b din=%02h adr=%0d dout=%02h dvalid=%0b", c, d, adr, dout, dvalid);
    endtask

    task automatic change_dly(input logic [4:0] new_dly);
        @(negedge clk);
        dly = new_dly;
        ce  = 1'b1;
        din = 8'hEE;
        #1;
        check("dlychg_we", we, 0);
        @(posedge clk);
        #1;
        check("dlychg_dvalid", dvalid, 0);
        check("dlychg_adr", adr, 0);
        check("dlychg_busy", busy, exp_busy_clear);
        model_reset(int'(new_dly) + 1);
        $display("[TB] DLY changed to %0d, dvalid=%0b adr=%0d busy=%0b", new_dly, dvalid, adr, busy);
        sweep();
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        din = '0;
        dly = 5'd3;
        model_reset(4);
        exp_dout       = '0;
        exp_dout_known = 1'b1;
        #1;
        check("rst_dout", dout, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_adr", adr, 0);
        check("rst_we", we, 0);
        check("rst_busy", busy, exp_busy_clear);
        $display("[TB] reset: dout=%02h dvalid=%0b adr=%0d we=%0b busy=%0b", dout, dvalid, adr, we, busy);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sweep();

        // L=4: stream 1..12, DVALID must first rise on RUN edge 5 carrying sample 1.
        for (int k = 1; k <= 12; k++) step(1'b1, 8'(k));
        // CE gaps must not count towards the delay.
        step(1'b1, 8'd13);
        step(1'b0, 8'h55);
        step(1'b0, 8'hAA);
        step(1'b1, 8'd14);
        step(1'b1, 8'd15);

        // L=8 after a restart.
        change_dly(5'd7);
        for (int k = 0; k < 12; k++) step(1'b1, 8'(8'h20 + k));

        // L=32: full address range, the sample at address 31 must round-trip.
        change_dly(5'd31);
        for (int k = 0; k < 40; k++) step(1'b1, 8'($urandom_range(0, 255)));

        // Asynchronous reset pulse in the middle of valid output.
        @(negedge clk);
        ce  = 1'b1;
        din = 8'h77;
        rst = 1'b1;
        #1;
        check("arst_dout", dout, 0);
        check("arst_dvalid", dvalid, 0);
        check("arst_adr", adr, 0);
        check("arst_we", we, 0);
        $display("[TB] async reset: dout=%02h dvalid=%0b adr=%0d we=%0b", dout, dvalid, adr, we);
        @(posedge clk);
        #1;
        check("arst_hold_adr", adr, 0);
        check("arst_hold_we", we, 0);
        @(negedge clk);
        ce  = 1'b0;
        rst = 1'b0;
        model_reset(32);
        exp_dout       = '0;
        exp_dout_known = 1'b1;
        #1;
        sweep();
        for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h40 + k));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
